// File: rtl/oam_dma_pkg.sv
// Shared definitions for the OAM DMA engine: default addresses, state
// encoding and a small trigger-decode helper.
package oam_dma_pkg;

    // CPU write address that kicks off a 256-byte sprite copy.
    localparam logic [15:0] DEF_TRIGGER_ADDR  = 16'h4014;
    // Every DMA write lands on this single OAM data port.
    localparam logic [15:0] DEF_OAM_DATA_ADDR = 16'h2004;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 2'd0,
        ST_ALIGN = 2'd1,
        ST_READ  = 2'd2,
        ST_WRITE = 2'd3
    } state_t;

    // True when the CPU is writing the trigger register this cycle.
    function automatic logic is_trigger(input logic        mw,
                                        input logic [15:0] addr,
                                        input logic [15:0] trig);
        return mw && (addr == trig);
    endfunction

endpackage

// File: rtl/oam_dma_if.sv
// Bus bundle between the CPU, the DMA engine and the system bus.
// The DMA engine sits in the middle: it sees the CPU request and the bus
// read data, and drives the bus request plus the CPU halt.
interface oam_dma_if;

    logic [15:0] cpu_aout;
    logic [7:0]  cpu_dout;
    logic        cpu_mr;
    logic        cpu_mw;
    logic [7:0]  din;
    logic        pause;
    logic [15:0] aout;
    logic [7:0]  dout;
    logic        mr;
    logic        mw;

    // DMA engine side.
    modport slave (
        input  cpu_aout,
        input  cpu_dout,
        input  cpu_mr,
        input  cpu_mw,
        input  din,
        output pause,
        output aout,
        output dout,
        output mr,
        output mw
    );

    // System side: supplies the CPU request and bus data, observes the bus.
    modport master (
        output cpu_aout,
        output cpu_dout,
        output cpu_mr,
        output cpu_mw,
        output din,
        input  pause,
        input  aout,
        input  dout,
        input  mr,
        input  mw
    );

endinterface

// File: rtl/oam_dma.sv
// OAM DMA engine. A CPU write of the page number to TRIGGER_ADDR halts the
// CPU and copies page:00..page:FF to OAM_DATA_ADDR as 256 read/write pairs.
// One or two alignment cycles precede the copy depending on the CPU-cycle
// parity at the trigger. All state advances only on ce; the bus outputs are
// a pure combinational function of the held state and the CPU request.
module oam_dma
    import oam_dma_pkg::*;
#(
    parameter logic [15:0] TRIGGER_ADDR  = DEF_TRIGGER_ADDR,
    parameter logic [15:0] OAM_DATA_ADDR = DEF_OAM_DATA_ADDR
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      ce,
    oam_dma_if.slave  bus
);

    state_t      state_reg, state_next;
    logic        parity_reg, parity_next;
    logic [7:0]  page_reg, page_next;
    logic [7:0]  idx_reg, idx_next;
    logic [7:0]  data_reg, data_next;
    // Set when the trigger landed on an odd cycle: ALIGN then lasts two cycles.
    logic        align_extra_reg, align_extra_next;

    // State register: reset wins over ce; otherwise only ce cycles advance.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= ST_IDLE;
            parity_reg      <= 1'b0;
            page_reg        <= 8'h00;
            idx_reg         <= 8'h00;
            data_reg        <= 8'h00;
            align_extra_reg <= 1'b0;
        end else if (ce) begin
            state_reg       <= state_next;
            parity_reg      <= parity_next;
            page_reg        <= page_next;
            idx_reg         <= idx_next;
            data_reg        <= data_next;
            align_extra_reg <= align_extra_next;
        end
    end

    // Next-state logic: sequencing, byte index and read-data capture.
    always_comb begin
        state_next       = state_reg;
        parity_next      = ~parity_reg;
        page_next        = page_reg;
        idx_next         = idx_reg;
        data_next        = data_reg;
        align_extra_next = align_extra_reg;

        case (state_reg)
            ST_IDLE: begin
                // CPU strobes are only decoded here, so a trigger write
                // during a transfer can never restart it.
                if (is_trigger(bus.cpu_mw, bus.cpu_aout, TRIGGER_ADDR)) begin
                    page_next        = bus.cpu_dout;
                    idx_next         = 8'h00;
                    align_extra_next = parity_reg;
                    state_next       = ST_ALIGN;
                end
            end
            ST_ALIGN: begin
                if (align_extra_reg) begin
                    align_extra_next = 1'b0;
                end else begin
                    state_next = ST_READ;
                end
            end
            ST_READ: begin
                data_next  = bus.din;
                state_next = ST_WRITE;
            end
            ST_WRITE: begin
                // The index is only 8 bits, so the source never carries
                // into the page; FF->00 happens exactly at termination.
                idx_next   = idx_reg + 8'h01;
                state_next = (idx_reg == 8'hFF) ? ST_IDLE : ST_READ;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Output logic: pass the CPU through in IDLE, otherwise own the bus.
    always_comb begin
        bus.pause = 1'b0;
        bus.aout  = bus.cpu_aout;
        bus.dout  = bus.cpu_dout;
        bus.mr    = bus.cpu_mr;
        bus.mw    = bus.cpu_mw;

        case (state_reg)
            ST_IDLE: begin
                bus.pause = 1'b0;
            end
            ST_ALIGN: begin
                // Dummy read on whatever address the halted CPU presents.
                bus.pause = 1'b1;
                bus.aout  = bus.cpu_aout;
                bus.mr    = 1'b1;
                bus.mw    = 1'b0;
            end
            ST_READ: begin
                bus.pause = 1'b1;
                bus.aout  = {page_reg, idx_reg};
                bus.dout  = data_reg;
                bus.mr    = 1'b1;
                bus.mw    = 1'b0;
            end
            ST_WRITE: begin
                bus.pause = 1'b1;
                bus.aout  = OAM_DATA_ADDR;
                bus.dout  = data_reg;
                bus.mr    = 1'b0;
                bus.mw    = 1'b1;
            end
            default: begin
                bus.pause = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_oam_dma.sv
// Self-checking bench for oam_dma: a scoreboard of expected per-cycle bus
// activity is filled at the trigger and drained on every paused ce cycle.
module tb_oam_dma;
    import oam_dma_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic ce;

    oam_dma_if bus_if();

    oam_dma #(
        .TRIGGER_ADDR (16'h4014),
        .OAM_DATA_ADDR(16'h2004)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .ce   (ce),
        .bus  (bus_if.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        logic        mr;
        logic        mw;
        logic [7:0]  data;
    } bus_txn_t;

    bus_txn_t exp_q[$];
    int checks = 0;
    int passes = 0;
    logic tb_parity;

    // Memory model: the byte returned for any source address.
    function automatic logic [7:0] mem_byte(input logic [15:0] a);
        return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h5A;
    endfunction

    always_comb bus_if.din = mem_byte(bus_if.aout);

    // Independent model of the CPU-cycle parity.
    always @(posedge clk) begin
        if (reset) tb_parity <= 1'b0;
        else if (ce) tb_parity <= ~tb_parity;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cpu(input logic [15:0] a, input logic [7:0] d,
                           input logic r, input logic w);
        bus_if.cpu_aout = a;
        bus_if.cpu_dout = d;
        bus_if.cpu_mr   = r;
        bus_if.cpu_mw   = w;
    endtask

    // Trigger a transfer at the requested parity and drain the scoreboard.
    // abort_after > 0 asserts reset once that many DMA writes have occurred.
    task automatic run_transfer(input logic [7:0] page, input logic want_par,
                                input bit rand_ce, input int abort_after,
                                input string tag);
        int       n_align;
        int       paused;
        int       writes;
        bit       done;
        bit       aborted;
        bus_txn_t e;
        logic [7:0] obs_d;

        set_cpu(16'h0300, 8'h00, 1'b0, 1'b0);
        ce = 1'b1;
        for (int g = 0; g < 4 && tb_parity !== want_par; g++) step();

        exp_q.delete();
        n_align = want_par ? 2 : 1;
        for (int a = 0; a < n_align; a++)
            exp_q.push_back('{addr: 16'h4014, mr: 1'b1, mw: 1'b0, data: 8'h00});
        for (int i = 0; i < 256; i++) begin
            exp_q.push_back('{addr: {page, i[7:0]}, mr: 1'b1, mw: 1'b0, data: 8'h00});
            exp_q.push_back('{addr: 16'h2004, mr: 1'b0, mw: 1'b1,
                              data: mem_byte({page, i[7:0]})});
        end

        // Trigger cycle: the write itself must pass straight through.
        set_cpu(16'h4014, page, 1'b0, 1'b1);
        @(negedge clk);
        checks++;
        if ({bus_if.pause, bus_if.aout, bus_if.dout, bus_if.mr, bus_if.mw} !==
            {1'b0, 16'h4014, page, 1'b0, 1'b1})
            $display("FAIL %s trigger_passthru: got pause=%b aout=%h dout=%h mr=%b mw=%b, want pause=0 aout=4014 dout=%h mr=0 mw=1",
                     tag, bus_if.pause, bus_if.aout, bus_if.dout, bus_if.mr, bus_if.mw, page);
        else passes++;
        step();

        paused  = 0;
        writes  = 0;
        done    = 1'b0;
        aborted = 1'b0;
        for (int c = 0; c < 4000 && !done; c++) begin
            if (abort_after > 0 && writes == abort_after) begin
                aborted = 1'b1;
                done    = 1'b1;
            end else begin
                ce = rand_ce ? 1'($urandom_range(0, 1)) : 1'b1;
                // Hammer the trigger register while busy; it must be ignored.
                if (exp_q.size() > 0) set_cpu(16'h4014, 8'hAA, 1'b0, 1'b1);
                else                  set_cpu(16'h0310, 8'h05, 1'b0, 1'b0);
                @(negedge clk);
                if (bus_if.pause !== 1'b1) begin
                    done = 1'b1;
                end else if (ce) begin
                    paused++;
                    checks++;
                    if (exp_q.size() == 0) begin
                        $display("FAIL %s extra_cycle: got paused cycle aout=%h mr=%b mw=%b, want none",
                                 tag, bus_if.aout, bus_if.mr, bus_if.mw);
                    end else begin
                        e = exp_q.pop_front();
                        obs_d = e.mw ? bus_if.dout : 8'h00;
                        if ({bus_if.aout, bus_if.mr, bus_if.mw, obs_d} !==
                            {e.addr, e.mr, e.mw, e.data})
                            $display("FAIL %s bus_cycle %0d: got aout=%h mr=%b mw=%b dout=%h, want aout=%h mr=%b mw=%b dout=%h",
                                     tag, paused, bus_if.aout, bus_if.mr, bus_if.mw, obs_d,
                                     e.addr, e.mr, e.mw, e.data);
                        else passes++;
                        if (e.mw) writes++;
                    end
                    step();
                end else begin
                    step();
                end
            end
        end

        if (!done) begin
            checks++;
            $display("FAIL %s timeout: got pause still high after 4000 cycles, want transfer end", tag);
        end else if (aborted) begin
            // Reset lands while ce is low: it must still take effect.
            reset = 1'b1;
            ce    = 1'b0;
            set_cpu(16'h1111, 8'h22, 1'b1, 1'b0);
            step();
            reset = 1'b0;
            ce    = 1'b1;
            @(negedge clk);
            checks++;
            if ({bus_if.pause, bus_if.aout, bus_if.dout, bus_if.mr, bus_if.mw} !==
                {1'b0, 16'h1111, 8'h22, 1'b1, 1'b0})
                $display("FAIL %s abort_idle: got pause=%b aout=%h dout=%h mr=%b mw=%b, want pause=0 aout=1111 dout=22 mr=1 mw=0",
                         tag, bus_if.pause, bus_if.aout, bus_if.dout, bus_if.mr, bus_if.mw);
            else passes++;
            step();
            for (int k = 0; k < 20; k++) begin
                ce = 1'($urandom_range(0, 1));
                @(negedge clk);
                checks++;
                if ({bus_if.pause, (bus_if.mw && bus_if.aout == 16'h2004)} !== 2'b00)
                    $display("FAIL %s abort_no_write: got pause=%b aout=%h mw=%b, want pause=0 and no OAM write",
                             tag, bus_if.pause, bus_if.aout, bus_if.mw);
                else passes++;
                step();
            end
            $display("transfer %s page=%h aborted after %0d writes", tag, page, writes);
        end else begin
            checks++;
            if (paused !== 512 + n_align)
                $display("FAIL %s pause_len: got %0d ce cycles, want %0d", tag, paused, 512 + n_align);
            else passes++;
            checks++;
            if (exp_q.size() !== 0)
                $display("FAIL %s leftover: got %0d unserved cycles, want 0", tag, exp_q.size());
            else passes++;
            checks++;
            if ({bus_if.pause, bus_if.aout, bus_if.dout, bus_if.mr, bus_if.mw} !==
                {1'b0, 16'h0310, 8'h05, 1'b0, 1'b0})
                $display("FAIL %s end_idle: got pause=%b aout=%h dout=%h mr=%b mw=%b, want pause=0 aout=0310 dout=05 mr=0 mw=0",
                         tag, bus_if.pause, bus_if.aout, bus_if.dout, bus_if.mr, bus_if.mw);
            else passes++;
            ce = 1'b1;
            step();
            @(negedge clk);
            checks++;
            if (bus_if.pause !== 1'b0)
                $display("FAIL %s stay_idle: got pause=%b, want 0", tag, bus_if.pause);
            else passes++;
            step();
            $display("transfer %s page=%h parity=%0d paused=%0d writes=%0d",
                     tag, page, want_par, paused, writes);
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ce    = 1'b0;
        set_cpu(16'h0123, 8'h45, 1'b1, 1'b0);
        step(); step(); step();
        @(negedge clk);
        checks++;
        if ({bus_if.pause, bus_if.aout, bus_if.dout, bus_if.mr, bus_if.mw} !==
            {1'b0, 16'h0123, 8'h45, 1'b1, 1'b0})
            $display("FAIL reset_state: got pause=%b aout=%h dout=%h mr=%b mw=%b, want pause=0 aout=0123 dout=45 mr=1 mw=0",
                     bus_if.pause, bus_if.aout, bus_if.dout, bus_if.mr, bus_if.mw);
        else passes++;
        reset = 1'b0;
        step();
        $display("reset done");
    endtask

    task automatic test_no_trigger();
        logic [15:0] a_tab [5] = '{16'h4015, 16'h4014, 16'h4014, 16'h4013, 16'h2004};
        logic [7:0]  d_tab [5] = '{8'h07,    8'h08,    8'h09,    8'h0A,    8'h0B};
        logic        r_tab [5] = '{1'b0,     1'b1,     1'b0,     1'b0,     1'b0};
        logic        w_tab [5] = '{1'b1,     1'b0,     1'b1,     1'b1,     1'b1};
        logic        c_tab [5] = '{1'b1,     1'b1,     1'b0,     1'b1,     1'b1};
        for (int i = 0; i < 5; i++) begin
            ce = c_tab[i];
            set_cpu(a_tab[i], d_tab[i], r_tab[i], w_tab[i]);
            @(negedge clk);
            checks++;
            if ({bus_if.pause, bus_if.aout, bus_if.dout, bus_if.mr, bus_if.mw} !==
                {1'b0, a_tab[i], d_tab[i], r_tab[i], w_tab[i]})
                $display("FAIL no_trigger[%0d]: got pause=%b aout=%h dout=%h mr=%b mw=%b, want pause=0 aout=%h dout=%h mr=%b mw=%b",
                         i, bus_if.pause, bus_if.aout, bus_if.dout, bus_if.mr, bus_if.mw,
                         a_tab[i], d_tab[i], r_tab[i], w_tab[i]);
            else passes++;
            step();
            $display("cpu access aout=%h mw=%b ce=%b passed through", a_tab[i], w_tab[i], c_tab[i]);
        end
        ce = 1'b1;
        set_cpu(16'h0000, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (bus_if.pause !== 1'b0)
            $display("FAIL no_trigger_final: got pause=%b, want 0", bus_if.pause);
        else passes++;
        step();
    endtask

    task automatic test_even_parity();  run_transfer(8'h02, 1'b0, 1'b0, 0, "even");   endtask
    task automatic test_odd_parity();   run_transfer(8'h02, 1'b1, 1'b0, 0, "odd");    endtask
    task automatic test_random_ce();    run_transfer(8'h3C, 1'b1, 1'b1, 0, "rand_ce"); endtask
    task automatic test_abort();        run_transfer(8'h05, 1'b0, 1'b0, 100, "abort"); endtask
    task automatic test_page_ff();      run_transfer(8'hFF, 1'b0, 1'b0, 0, "page_ff"); endtask
    task automatic test_back_to_back(); run_transfer(8'h81, 1'b1, 1'b1, 0, "b2b");    endtask

    initial begin
        reset = 1'b1;
        ce    = 1'b0;
        set_cpu(16'h0000, 8'h00, 1'b0, 1'b0);
        test_reset();
        test_no_trigger();
        test_even_parity();
        test_odd_parity();
        test_random_ce();
        test_abort();
        test_page_ff();
        test_back_to_back();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
